// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: D = A - B - Bi, LSB first.
// One bit per RUN cycle; result and borrow appear together with done.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Bi,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bo
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  a_d;
  logic [W-1:0]  b_q;
  logic [W-1:0]  b_d;
  logic          br_q;
  logic          br_d;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_d;
  logic [W-1:0]  d_q;
  logic [W-1:0]  d_d;
  logic          bo_q;
  logic          bo_d;
  logic          done_q;
  logic          done_d;

  logic          accept;
  logic          last;
  logic          bit_d;
  logic          bit_br;
  logic [W-1:0]  res_nxt;

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == RUN) && (cnt_q == LAST);

  // Full-subtractor cell on the current LSBs
  assign bit_d   = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_br  = (~a_q[0] & b_q[0])
                 | (~(a_q[0] ^ b_q[0]) & br_q);
  assign res_nxt = {bit_d, res_q[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = done_q;
    D    = d_q;
    Bo   = bo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    res_d  = res_q;
    d_d    = d_q;
    bo_d   = bo_q;
    done_d = 1'b0;
    unique case (1'b1)
      accept: begin
        cnt_d = '0;
        a_d   = A;
        b_d   = B;
        br_d  = Bi;
        res_d = '0;
      end
      (state_q == RUN): begin
        cnt_d = cnt_q + 1'b1;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bit_br;
        res_d = res_nxt;
        if (last) begin
          d_d    = res_nxt;
          bo_d   = bit_br;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      res_q  <= '0;
      d_q    <= '0;
      bo_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      res_q  <= res_d;
      d_q    <= d_d;
      bo_q   <= bo_d;
      done_q <= done_d;
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter W, default 4, giving the operand and result width in bits (W >= 2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled on the rising clk edge.
REQ-005 SHALL have port A  input  W  minuend; sampled only on an accepted start.
REQ-006 SHALL have port B  input  W  subtrahend; sampled only on an accepted start.
REQ-007 SHALL have port Bi  input  1  borrow-in; sampled only on an accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when D and Bo are updated.
REQ-010 SHALL have port D  output  W  registered difference, A - B - Bi mod 2^W.
REQ-011 SHALL have port Bo  output  1  registered borrow-out; 1 iff A < B + Bi as unsigned values.

Function
REQ-012 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-013 SHALL accept start only in IDLE: on an edge with start=1, it latches A, B and Bi, clears the bit counter, and enters RUN with busy=1 from the next cycle.
REQ-014 SHALL ignore start while in RUN, with no effect on operands, counter or outputs.
REQ-015 SHALL process one bit per RUN cycle, LSB first: d = a XOR b XOR br; br_next = (~a & b) | (~(a XOR b) & br); br initial = latched Bi.
REQ-016 SHALL shift the operand registers right by one and shift d into a W-bit internal result register on each RUN edge.
REQ-017 SHALL use a bit counter of width ceil(log2(W+1)) that increments per RUN edge; on the edge completing bit W-1, it returns to IDLE.
REQ-018 SHALL load D with the full W-bit result and Bo with the final br on that same completing edge, and raise done for exactly that following cycle.
REQ-019 SHALL hold D and Bo at their previous values throughout RUN, changing them only at completion.
REQ-020 SHALL have a fixed latency: if start is accepted at edge k, done=1 and the new D/Bo are visible in the cycle after edge k+W; busy=1 for the W cycles after edge k and 0 in the done cycle.
REQ-021 SHALL accept a start in the done cycle (state IDLE), giving back-to-back operations every W+1 cycles.
REQ-022 SHALL not gate the result by input changes on A, B or Bi after acceptance.

Reset
REQ-023 SHALL, on rst_n=0 and independent of clk, force state IDLE, busy=0, done=0, D=0, Bo=0, counter=0, and clear internal operand/result/borrow registers.
REQ-024 SHALL abort any operation in progress on reset mid-RUN, with no done pulse and D/Bo=0 afterwards.
REQ-025 SHALL ignore start while rst_n=0, and accept it on the first rising edge after rst_n deasserts.

Verification
REQ-026 SHALL pass the basic case: A=1010, B=0101, Bi=0 -> after W=4 cycles done pulse, D=0101, Bo=0.
REQ-027 SHALL pass the wrap-around/borrow case: A=0001, B=1111, Bi=1 -> D=0001, Bo=1; A=0100, B=0111, Bi=1 -> D=1100, Bo=1; A=0011, B=0010, Bi=0 -> D=0001, Bo=0.
REQ-028 SHALL pass the busy-ignore case: start A=1010, B=0101, Bi=0, then pulse start with A=1111, B=0000 two cycles later -> single done after 4 cycles, D=0101, Bo=0, only one done pulse.
REQ-029 SHALL pass the back-to-back case: assert start in the done cycle with A=0000, B=0001, Bi=0 -> second done exactly 5 cycles after the first, D=1111, Bo=1.
REQ-030 SHALL pass the reset-mid-operation case: rst_n low 2 cycles after start -> busy=0, done=0, D=0000, Bo=0 immediately; no done pulse thereafter until a new start.
REQ-031 SHALL pass a self-checking exhaustive sweep at W=4: all A, B in 0..15 and Bi in 0..1 -> D == (A-B-Bi) mod 16 and Bo == (A < B+Bi) for every case.
